// File: rtl/imem_dmem_arbiter_pkg.sv
// Shared definitions for the fetch / load-store memory arbiter.
//   owner_e   : which requester the read data of the previous grant belongs to
//   DEF_*     : default widths and starvation limit
package imem_dmem_arbiter_pkg;

  localparam int unsigned DEF_ADDR_WIDTH   = 32;
  localparam int unsigned DEF_DATA_WIDTH   = 32;
  localparam int unsigned DEF_MEM_AW       = 10;
  localparam int unsigned DEF_STARVE_LIMIT = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2
  } owner_e;

endpackage

// File: rtl/imem_dmem_arbiter_if.sv
// Bus bundle between the pipeline requesters, the arbiter and the memory.
//   fetch side : if_req/if_addr in, if_gnt/if_stall/if_rdata/if_rvalid out
//   ls side    : ls_req/ls_we/ls_be/ls_addr/ls_wdata in,
//                ls_gnt/ls_stall/ls_rdata/ls_rvalid out
//   memory side: mem_en/mem_we/mem_be/mem_addr/mem_wdata out, mem_rdata in
// Modport slave is the arbiter view; master is the surrounding system view
// (requesters plus memory).
interface imem_dmem_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_AW     = 10
);
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_gnt;
  logic                  if_stall;
  logic [DATA_WIDTH-1:0] if_rdata;
  logic                  if_rvalid;

  logic                  ls_req;
  logic                  ls_we;
  logic [3:0]            ls_be;
  logic [ADDR_WIDTH-1:0] ls_addr;
  logic [DATA_WIDTH-1:0] ls_wdata;
  logic                  ls_gnt;
  logic                  ls_stall;
  logic [DATA_WIDTH-1:0] ls_rdata;
  logic                  ls_rvalid;

  logic                  mem_en;
  logic                  mem_we;
  logic [3:0]            mem_be;
  logic [MEM_AW-1:0]     mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_stall, if_rdata, if_rvalid,
    input  ls_req, ls_we, ls_be, ls_addr, ls_wdata,
    output ls_gnt, ls_stall, ls_rdata, ls_rvalid,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_stall, if_rdata, if_rvalid,
    output ls_req, ls_we, ls_be, ls_addr, ls_wdata,
    input  ls_gnt, ls_stall, ls_rdata, ls_rvalid,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/imem_dmem_arbiter_starve_cnt.sv
// Saturating count of consecutive cycles in which fetch asked and lost.
//   clk, rst_n  : clock, async active-low reset
//   cpu_en      : counting only happens while enabled (holds otherwise)
//   if_req      : fetch request; clears the count when low
//   if_gnt      : fetch grant; clears the count
//   force_fetch : count has reached STARVE_LIMIT, fetch must win next
module imem_dmem_arbiter_starve_cnt #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cpu_en,
  input  logic if_req,
  input  logic if_gnt,
  output logic force_fetch
);

  localparam int unsigned CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!if_req || if_gnt) begin
      cnt_d = '0;
    end else if (cpu_en && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign force_fetch = (cnt_q == LIMIT);

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Shares one single-port synchronous memory between instruction fetch and
// load/store. Load/store has fixed priority; after STARVE_LIMIT consecutive
// lost fetch cycles the fetch port is forced through for one grant. Read
// data returns with a one-cycle rvalid pulse to whoever owned the grant.
//   clk, rst_n : clock, async active-low reset
//   cpu_en     : global enable, no grants while low
//   bus        : fetch, load/store and memory signals (slave modport)
module imem_dmem_arbiter
  import imem_dmem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int unsigned MEM_AW       = DEF_MEM_AW,
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_en,
  imem_dmem_arbiter_if.slave bus
);

  logic   force_fetch;
  logic   active;
  logic   if_gnt;
  logic   ls_gnt;
  logic   ls_store;
  owner_e owner_q;
  owner_e owner_d;

  // Word-address bits only; byte offset and upper bits are dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.if_addr[ADDR_WIDTH-1:MEM_AW+2], bus.if_addr[1:0],
                              bus.ls_addr[ADDR_WIDTH-1:MEM_AW+2], bus.ls_addr[1:0]};

  imem_dmem_arbiter_starve_cnt #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_en     (cpu_en),
    .if_req     (bus.if_req),
    .if_gnt     (if_gnt),
    .force_fetch(force_fetch)
  );

  // rst_n is folded in so every output reads 0 while reset is asserted,
  // even with requests held high.
  assign active   = rst_n & cpu_en;
  assign if_gnt   = active & bus.if_req & (~bus.ls_req | force_fetch);
  assign ls_gnt   = active & bus.ls_req & ~(bus.if_req & force_fetch);
  assign ls_store = ls_gnt & bus.ls_we;

  always_comb begin
    owner_d = OWN_NONE;
    if (if_gnt) begin
      owner_d = OWN_IF;
    end else if (ls_gnt && !bus.ls_we) begin
      owner_d = OWN_LS;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  always_comb begin
    bus.if_gnt    = if_gnt;
    bus.ls_gnt    = ls_gnt;
    bus.if_stall  = rst_n & bus.if_req & ~if_gnt;
    bus.ls_stall  = rst_n & bus.ls_req & ~ls_gnt;

    bus.mem_en    = if_gnt | ls_gnt;
    bus.mem_we    = ls_store;
    bus.mem_be    = '0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (ls_gnt) begin
      bus.mem_addr = bus.ls_addr[MEM_AW+1:2];
      bus.mem_be   = ls_store ? bus.ls_be : 4'b1111;
      if (ls_store) begin
        bus.mem_wdata = bus.ls_wdata;
      end
    end else if (if_gnt) begin
      bus.mem_addr = bus.if_addr[MEM_AW+1:2];
      bus.mem_be   = 4'b1111;
    end

    bus.if_rvalid = (owner_q == OWN_IF);
    bus.ls_rvalid = (owner_q == OWN_LS);
    bus.if_rdata  = (owner_q == OWN_IF) ? bus.mem_rdata : '0;
    bus.ls_rdata  = (owner_q == OWN_LS) ? bus.mem_rdata : '0;
  end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed bench for imem_dmem_arbiter with a byte-enabled memory model.
// Grant-cycle signals are checked by the stimulus; read data is pushed to
// per-port queues and checked by a monitor when rvalid appears.
module tb_imem_dmem_arbiter;

  logic clk;
  logic rst_n;
  logic cpu_en;
  logic preload;
  logic mon_on;

  int total;
  int bad;

  logic [31:0] if_q[$];
  logic [31:0] ls_q[$];
  logic [31:0] mem [0:1023];

  imem_dmem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_AW(10)) bus ();

  imem_dmem_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_AW(10), .STARVE_LIMIT(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cpu_en(cpu_en),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port synchronous memory with byte enables.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 1024; i++) mem[i] <= '0;
      mem[0]  <= 32'h0000_0013;
      mem[1]  <= 32'h0000_0093;
      mem[2]  <= 32'h0010_0113;
      mem[4]  <= 32'hA0A0_A0A0;
      mem[16] <= 32'h1234_5678;
      bus.mem_rdata <= '0;
    end else if (bus.mem_en) begin
      if (bus.mem_we) begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_be[b]) mem[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      end else begin
        bus.mem_rdata <= mem[bus.mem_addr];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops expected read data whenever rvalid is seen.
  always @(negedge clk) begin
    if (mon_on) begin
      if (bus.if_rvalid) begin
        if (if_q.size() == 0) chk("if_rvalid_extra", 32'(bus.if_rvalid), 32'd0);
        else chk("if_rdata", bus.if_rdata, if_q.pop_front());
      end else begin
        chk("if_rdata_idle", bus.if_rdata, 32'd0);
      end
      if (bus.ls_rvalid) begin
        if (ls_q.size() == 0) chk("ls_rvalid_extra", 32'(bus.ls_rvalid), 32'd0);
        else chk("ls_rdata", bus.ls_rdata, ls_q.pop_front());
      end else begin
        chk("ls_rdata_idle", bus.ls_rdata, 32'd0);
      end
    end
  end

  // One request cycle: drive, check grant-cycle outputs at negedge, push the
  // expected read data, advance to just after the next rising edge.
  task automatic step(input bit en, input bit ir, input logic [31:0] ia,
                      input bit lr, input bit lw, input logic [3:0] lb,
                      input logic [31:0] la, input logic [31:0] lwd,
                      input bit e_ig, input bit e_lg, input logic [9:0] e_ma,
                      input logic [31:0] e_data, input bit push);
    cpu_en       = en;
    bus.if_req   = ir;
    bus.if_addr  = ia;
    bus.ls_req   = lr;
    bus.ls_we    = lw;
    bus.ls_be    = lb;
    bus.ls_addr  = la;
    bus.ls_wdata = lwd;
    @(negedge clk);
    chk("if_gnt",   32'(bus.if_gnt),   32'(e_ig));
    chk("ls_gnt",   32'(bus.ls_gnt),   32'(e_lg));
    chk("if_stall", 32'(bus.if_stall), 32'(ir & ~e_ig));
    chk("ls_stall", 32'(bus.ls_stall), 32'(lr & ~e_lg));
    chk("mem_en",   32'(bus.mem_en),   32'(e_ig | e_lg));
    chk("mem_we",   32'(bus.mem_we),   32'(e_lg & lw));
    if (e_ig | e_lg) begin
      chk("mem_addr", 32'(bus.mem_addr), 32'(e_ma));
      chk("mem_be",   32'(bus.mem_be),   (e_lg & lw) ? 32'(lb) : 32'hF);
      if (e_lg & lw) chk("mem_wdata", bus.mem_wdata, lwd);
    end
    if (push) begin
      if (e_ig) if_q.push_back(e_data);
      else if (e_lg && !lw) ls_q.push_back(e_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++)
      step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 10'h0, 32'h0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    total = 0; bad = 0; mon_on = 1'b0;
    rst_n = 1'b0; preload = 1'b1; cpu_en = 1'b1;
    bus.if_req = 1'b1; bus.if_addr = '0;
    bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_be = 4'hF;
    bus.ls_addr = '0; bus.ls_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    // Reset state, with both requests held high.
    chk("rst_if_gnt",    32'(bus.if_gnt),    32'd0);
    chk("rst_ls_gnt",    32'(bus.ls_gnt),    32'd0);
    chk("rst_if_stall",  32'(bus.if_stall),  32'd0);
    chk("rst_ls_stall",  32'(bus.ls_stall),  32'd0);
    chk("rst_mem_en",    32'(bus.mem_en),    32'd0);
    chk("rst_if_rvalid", 32'(bus.if_rvalid), 32'd0);
    chk("rst_ls_rvalid", 32'(bus.ls_rvalid), 32'd0);
    @(posedge clk);
    #1;
    preload = 1'b0; rst_n = 1'b1; mon_on = 1'b1;
    idle(1);

    // Fetch-only stream.
    step(1, 1, 32'h0, 0, 0, 4'hF, 32'h0, 32'h0, 1, 0, 10'h0, 32'h0000_0013, 1);
    step(1, 1, 32'h4, 0, 0, 4'hF, 32'h0, 32'h0, 1, 0, 10'h1, 32'h0000_0093, 1);
    step(1, 1, 32'h8, 0, 0, 4'hF, 32'h0, 32'h0, 1, 0, 10'h2, 32'h0010_0113, 1);
    idle(1);

    // Collision: load wins, fetch follows next cycle.
    step(1, 1, 32'h10, 1, 0, 4'hF, 32'h40, 32'h0, 0, 1, 10'h10, 32'h1234_5678, 1);
    step(1, 1, 32'h10, 0, 0, 4'hF, 32'h40, 32'h0, 1, 0, 10'h4,  32'hA0A0_A0A0, 1);
    idle(1);

    // Starvation guard: 4 ls grants, forced fetch, ls resumes.
    for (int c = 0; c < 8; c++) begin
      if (c == 4)
        step(1, 1, 32'h10, 1, 0, 4'hF, 32'h40, 32'h0, 1, 0, 10'h4,  32'hA0A0_A0A0, 1);
      else
        step(1, 1, 32'h10, 1, 0, 4'hF, 32'h40, 32'h0, 0, 1, 10'h10, 32'h1234_5678, 1);
    end
    idle(1);

    // Partial store then read back (misaligned byte bits ignored on read).
    step(1, 0, 32'h0, 1, 1, 4'b0011, 32'h20, 32'hDEAD_BEEF, 0, 1, 10'h8, 32'h0, 0);
    step(1, 0, 32'h0, 1, 0, 4'hF,    32'h23, 32'h0,         0, 1, 10'h8, 32'h0000_BEEF, 1);
    idle(1);

    // cpu_en low: no grants and the starve counter must not advance.
    for (int c = 0; c < 6; c++)
      step(0, 1, 32'h0, 1, 0, 4'hF, 32'h40, 32'h0, 0, 0, 10'h0, 32'h0, 0);
    step(1, 1, 32'h0, 1, 0, 4'hF, 32'h40, 32'h0, 0, 1, 10'h10, 32'h1234_5678, 1);
    idle(1);

    // Reset during the rvalid cycle of a fetch.
    step(1, 1, 32'h0, 0, 0, 4'hF, 32'h0, 32'h0, 1, 0, 10'h0, 32'h0, 0);
    rst_n = 1'b0;
    bus.ls_req = 1'b1;
    #1;
    chk("arst_if_rvalid", 32'(bus.if_rvalid), 32'd0);
    chk("arst_if_rdata",  bus.if_rdata,       32'd0);
    chk("arst_if_gnt",    32'(bus.if_gnt),    32'd0);
    chk("arst_ls_gnt",    32'(bus.ls_gnt),    32'd0);
    chk("arst_if_stall",  32'(bus.if_stall),  32'd0);
    chk("arst_ls_stall",  32'(bus.ls_stall),  32'd0);
    chk("arst_mem_en",    32'(bus.mem_en),    32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1, 1, 32'h10, 1, 0, 4'hF, 32'h40, 32'h0, 0, 1, 10'h10, 32'h1234_5678, 1);
    step(1, 1, 32'h10, 0, 0, 4'hF, 32'h40, 32'h0, 1, 0, 10'h4,  32'hA0A0_A0A0, 1);
    idle(3);

    chk("if_q_drained", 32'(if_q.size()), 32'd0);
    chk("ls_q_drained", 32'(ls_q.size()), 32'd0);
    mon_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_dmem_arbiter.md
Name: imem_dmem_arbiter

Overview:
- Shares one single-port synchronous memory (the program/data image, "disk") between two requesters: the pipeline fetch port and the load/store port.
- Sits between pipeline_cpu_top and the memory model/macro.
- Issues per-cycle grants, routes read data back with a valid pulse one cycle after grant, and raises stall toward the losing requester.
- Fixed priority to load/store, with a starvation guard that forces a fetch grant.

Parameters:
- ADDR_WIDTH, 32, byte address width of both requesters and the memory port (`PC_WIDTH).
- DATA_WIDTH, 32, word width (`WORD_WIDTH).
- MEM_AW, 10, word-address width driven to memory; memory address = addr[MEM_AW+1:2].
- STARVE_LIMIT, 4, consecutive denied fetch cycles after which fetch wins one grant.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cpu_en  in  1  global enable; when low no grants are issued
- if_req  in  1  fetch request (rd_insn_en)
- if_addr  in  ADDR_WIDTH  fetch byte address (pc)
- if_gnt  out  1  fetch accepted this cycle
- if_stall  out  1  if_req & ~if_gnt
- if_rdata  out  DATA_WIDTH  instruction word
- if_rvalid  out  1  if_rdata valid (one cycle after if_gnt)
- ls_req  in  1  load/store request
- ls_we  in  1  1 = store
- ls_be  in  4  byte enables for store
- ls_addr  in  ADDR_WIDTH  data byte address
- ls_wdata  in  DATA_WIDTH  store data
- ls_gnt  out  1  load/store accepted this cycle
- ls_stall  out  1  ls_req & ~ls_gnt
- ls_rdata  out  DATA_WIDTH  load data
- ls_rvalid  out  1  ls_rdata valid (one cycle after a load grant)
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write
- mem_be  out  4  memory byte enables
- mem_addr  out  MEM_AW  memory word address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data, valid the cycle after mem_en & ~mem_we

Behaviour:
- Reset: all outputs 0; owner register = NONE; starve counter = 0.
- Grant decision is combinational in the request cycle. At most one grant per cycle.
  - cpu_en=0: no grant; starve counter holds.
  - Only one request present: that request is granted.
  - Both present and starve_cnt < STARVE_LIMIT: ls granted.
  - Both present and starve_cnt == STARVE_LIMIT: if granted.
- Starve counter:
  - Increments when if_req & ~if_gnt & cpu_en, saturating at STARVE_LIMIT.
  - Clears on if_gnt or when if_req=0.
- Memory drive: mem_en = any grant. mem_we/mem_be/mem_wdata come from ls only on a ls store grant; fetch is always a read with be=4'b1111 ignored.
- Misaligned address (addr[1:0] != 0): bits are dropped, no error.
- Owner register: on the clock edge after a read grant, holds IF or LS; otherwise NONE.
  - owner=IF: if_rvalid=1 and if_rdata=mem_rdata.
  - owner=LS: ls_rvalid=1 and ls_rdata=mem_rdata.
  - Unselected rdata outputs are driven 0.
- Stores: complete at grant; no ls_rvalid.
- Requester rules: a requester holds req/addr/data stable while stalled. The arbiter does not latch requests; dropping a req before grant cancels it.
- Back-to-back grants are allowed every cycle (full throughput). Read data for grant N and grant N+1 return in consecutive cycles.
- Async reset mid-access: an in-flight rvalid is killed; the owner returns to NONE immediately.

Decomposition:
- Shared define.v gets: owner encoding (`OWN_NONE=2'd0, `OWN_IF=2'd1, `OWN_LS=2'd2) and `MEM_AW default.
- Existing `PC_WIDTH/`WORD_WIDTH are reused.
- One natural sub-module: arb_starve_cnt, the saturating starvation counter plus the force-fetch flag.

Test Plan:
- Only fetch, cpu_en=1, if_addr=0x0,0x4,0x8 on successive cycles, memory holds 0x00000013 at word 0 -> if_gnt every cycle, if_rvalid from cycle+1, if_rdata=0x00000013 first, if_stall=0.
- Fetch and load collide on one cycle: if_addr=0x10, ls_addr=0x40, ls_we=0 -> ls_gnt=1, if_stall=1, mem_addr=0x10. Next cycle: ls_rvalid=1, if_gnt=1, mem_addr=0x4.
- Continuous ls_req for 8 cycles with if_req held, STARVE_LIMIT=4 -> ls granted cycles 0-3, if granted cycle 4, ls resumes cycle 5. Counter returns to 0 after the if grant.
- Store ls_we=1, ls_be=4'b0011, ls_addr=0x20, wdata=0xDEADBEEF -> mem_en=1, mem_we=1, mem_addr=0x8, mem_be=0011 in the grant cycle. No ls_rvalid. A following read of 0x20 returns 0x0000BEEF over a zeroed word.
- cpu_en=0 with both requests -> no grants, both stalls=1, mem_en=0. cpu_en rising -> ls granted first cycle.
- rst_n pulled low the cycle after a fetch grant -> if_rvalid=0 immediately, all outputs 0. After release, the first request is granted normally.
